alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the EV22 datapath, generalising the 16-bit combinational ALU. It adds a configurable word width, subtraction, variable shifts and an iterative unsigned multiply. Operands enter and results leave through valid/ready handshakes, and the result is registered. It sits between the register-file read buses and the writeback/flags stage. Single-cycle ops complete in one cycle, and shift/multiply ops stall the issuing stage through `in_ready`.

## Interface
- `WIDTH`, 16: datapath width in bits (≥4, power of two).
- `CW`, `$clog2(WIDTH)`: shift-count width (derived; do not override).

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand/op presented.
- `in_ready` output 1: block can accept; transfer when `in_valid && in_ready`.
- `busA`, `busB` input WIDTH: operands.
- `CY` input 1: carry-in flag.
- `ALU_op` input 5: operation select.
- `out_valid` output 1: result held on `Zout`/`CYout`/`ZF`.
- `out_ready` input 1: consumer takes result.
- `Zout` output WIDTH: result (registered).
- `CYout` output 1: carry/borrow flag (registered).
- `ZF` output 1: `Zout == 0` (registered).

## Operation
- `busA`, `busB`, `CY` and `ALU_op` are captured on acceptance. Inputs are ignored at all other times.
- Ops 0–14 (single-cycle):
  - 0 A; 1 B; 2 ~A; 3 ~B.
  - 4 A+B; 5 A+B+CY. For both, CYout is bit WIDTH of the (WIDTH+1)-bit sum.
  - 6 A|B; 7 A&B.
  - 8 zero; 9 one; 10 all-ones.
  - 11 zero with CYout=0; 12 one with CYout=1.
  - 13 A+1, CYout=(result==0).
  - 14 A−1, CYout=(result==all-ones).
  - For all ops above without a stated CYout rule, CYout=CY.
- Op 15 SUB (single-cycle): A−B mod 2^WIDTH, CYout=(A<B unsigned), i.e. borrow.
- Ops 16–18 (multi-cycle shifts). Count n = `busB[CW-1:0]`. One bit position per cycle.
  - 16 SHL: zero fill; bit shifted out is bit WIDTH−1.
  - 17 SHR: zero fill; bit shifted out is bit 0.
  - 18 SAR: sign fill; bit shifted out is bit 0.
  - CYout = last bit shifted out. If n=0, result=A and CYout=CY.
- Op 19 MUL (multi-cycle): unsigned shift-add, one multiplier bit per cycle, WIDTH iterations.
  - Zout = low WIDTH bits of A×B.
  - CYout = 1 iff the high WIDTH bits are non-zero.
- Ops 20–31: Zout=0, CYout=CY (single-cycle).
- ZF is always computed from the final Zout.
- State machine:
  - IDLE: `in_ready`=1. On accept, single-cycle ops and shifts with n=0 go to DONE with the result loaded. Other shifts and MUL go to RUN, with the iteration counter loaded to n or WIDTH.
  - RUN: `in_ready`=0. One iteration per cycle; counter decrements. Go to DONE when the final iteration is written.
  - DONE: `out_valid`=1, `in_ready`=0. Go to IDLE on `out_ready`.
- Working registers: accumulator 2·WIDTH bits for MUL, shift register WIDTH bits, counter CW+1 bits.

## Timing
- Reset (async assert, anywhere including RUN or DONE), effective immediately:
  - state=IDLE, `in_ready`=1, `out_valid`=0.
  - `Zout`=0, `CYout`=0, `ZF`=0, counter=0.
  - Any in-flight op is discarded.
- Latency, counted from the accept edge to the first edge with `out_valid`=1:
  - Single-cycle ops: 1.
  - Shifts: n+1, or 1 if n=0.
  - MUL: WIDTH+1.
- `Zout`/`CYout`/`ZF` are stable for the whole time `out_valid`=1. They keep their last value after the handshake completes.
- No result overlap: after an `out_ready` handshake there is one IDLE cycle. Peak throughput is one op per 2 cycles.
- `in_valid` during RUN or DONE is not accepted. The producer must hold it.
- `out_ready` asserted before `out_valid` has no effect.

## Test plan
- ADD (op 4), A=0xFFFF, B=0x0001, CY=0 → Zout=0x0000, CYout=1, ZF=1, `out_valid` one cycle after accept. Then SUB A=0x0003, B=0x0005 → 0xFFFE, CYout=1.
- SHL (op 16), A=0x2001, B=3 → 0x0008, CYout=1, `out_valid` 4 cycles after accept. SAR (op 18), A=0x8000, B=15 → 0xFFFF, CYout=0. SHR with B=0, CY=1 → Zout=A, CYout=1, latency 1.
- MUL (op 19), 0x00FF×0x0003 → 0x02FD, CYout=0, latency 17. Then 0x0100×0x0100 → 0x0000, CYout=1, ZF=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after a DEC of 0x0000. Expect Zout=0xFFFF and CYout=1 held, `in_ready`=0, and a new `in_valid` ignored. Release `out_ready` → IDLE the next cycle, then the pending op is accepted.
- Reset mid-op: assert `rst_n`=0 during cycle 8 of a MUL. Expect `out_valid`=0, `in_ready`=1, Zout=0, CYout=0 immediately. A new INC of 0xFFFF after release → 0x0000, CYout=1.
- Default/flag ops: op 25 with CY=1 → Zout=0, CYout=1. Op 12 → Zout=0x0001, CYout=1. Op 11 → 0, CYout=0.

Source files
------------

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result valid-ready bundle for the multi-cycle ALU.
// master = issuing stage and consumer, slave = the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic             CY;
    logic [4:0]       ALU_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Zout;
    logic             CYout;
    logic             ZF;

    modport master (
        output in_valid, busA, busB, CY, ALU_op, out_ready,
        input  in_ready, out_valid, Zout, CYout, ZF
    );

    modport slave (
        input  in_valid, busA, busB, CY, ALU_op, out_ready,
        output in_ready, out_valid, Zout, CYout, ZF
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: parameterised multi-cycle ALU with valid/ready in/out handshakes.
// Shifts iterate one bit per cycle; MUL is radix-2 shift-add.
module alu_mc #(
    parameter int WIDTH = 16,
    localparam int CW = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {K_SHL, K_SHR, K_SAR, K_MUL} kind_t;

    localparam logic [CW:0] CNT_ONE = (CW+1)'(1);
    localparam logic [CW:0] CNT_W   = (CW+1)'(WIDTH);

    state_t               state_q;
    kind_t                kind_q;
    logic [CW:0]          cnt_q;
    logic [WIDTH-1:0]     sh_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     zout_q;
    logic                 cy_q;
    logic                 zf_q;
    logic                 rdy_q;
    logic                 vld_q;

    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [CW-1:0]        n;
    logic                 accept;
    logic                 is_shift;
    logic                 is_mul;

    assign a        = bus.busA;
    assign b        = bus.busB;
    assign n        = b[CW-1:0];
    assign accept   = bus.in_valid && rdy_q;
    assign is_shift = bus.ALU_op inside {5'd16, 5'd17, 5'd18};
    assign is_mul   = bus.ALU_op == 5'd19;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     res_c;
    logic                 cy_c;

    // Shifts by zero share this path: result is A, carry passes through.
    always_comb begin
        sum   = '0;
        res_c = '0;
        cy_c  = bus.CY;
        unique case (bus.ALU_op)
            5'd0:  res_c = a;
            5'd1:  res_c = b;
            5'd2:  res_c = ~a;
            5'd3:  res_c = ~b;
            5'd4: begin
                sum   = {1'b0, a} + {1'b0, b};
                res_c = sum[WIDTH-1:0];
                cy_c  = sum[WIDTH];
            end
            5'd5: begin
                sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, bus.CY};
                res_c = sum[WIDTH-1:0];
                cy_c  = sum[WIDTH];
            end
            5'd6:  res_c = a | b;
            5'd7:  res_c = a & b;
            5'd8:  res_c = '0;
            5'd9:  res_c = WIDTH'(1);
            5'd10: res_c = '1;
            5'd11: begin
                res_c = '0;
                cy_c  = 1'b0;
            end
            5'd12: begin
                res_c = WIDTH'(1);
                cy_c  = 1'b1;
            end
            5'd13: begin
                res_c = a + WIDTH'(1);
                cy_c  = res_c == '0;
            end
            5'd14: begin
                res_c = a - WIDTH'(1);
                cy_c  = &res_c;
            end
            5'd15: begin
                res_c = a - b;
                cy_c  = a < b;
            end
            5'd16, 5'd17, 5'd18: res_c = a;
            default: res_c = '0;
        endcase
    end

    logic [WIDTH-1:0]     sh_n;
    logic                 shcy_n;
    logic [WIDTH:0]       madd;
    logic [2*WIDTH-1:0]   acc_n;
    logic [WIDTH-1:0]     fin_z;
    logic                 fin_cy;

    always_comb begin
        sh_n   = sh_q;
        shcy_n = 1'b0;
        unique case (kind_q)
            K_SHL: begin
                sh_n   = {sh_q[WIDTH-2:0], 1'b0};
                shcy_n = sh_q[WIDTH-1];
            end
            K_SHR: begin
                sh_n   = {1'b0, sh_q[WIDTH-1:1]};
                shcy_n = sh_q[0];
            end
            K_SAR: begin
                sh_n   = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                shcy_n = sh_q[0];
            end
            default: ;
        endcase
    end

    // Multiplier sits in the low half of acc and is consumed from bit 0.
    assign madd   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, {WIDTH{acc_q[0]}} & mcand_q};
    assign acc_n  = {madd, acc_q[WIDTH-1:1]};
    assign fin_z  = (kind_q == K_MUL) ? acc_n[WIDTH-1:0] : sh_n;
    assign fin_cy = (kind_q == K_MUL) ? |acc_n[2*WIDTH-1:WIDTH] : shcy_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_SHL;
            cnt_q   <= '0;
            sh_q    <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            zout_q  <= '0;
            cy_q    <= 1'b0;
            zf_q    <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (accept) begin
                    kind_q  <= kind_t'(bus.ALU_op[1:0]);
                    sh_q    <= a;
                    mcand_q <= a;
                    acc_q   <= {{WIDTH{1'b0}}, b};
                    rdy_q   <= 1'b0;
                    if (is_mul || (is_shift && n != '0)) begin
                        cnt_q   <= is_mul ? CNT_W : {1'b0, n};
                        state_q <= S_RUN;
                    end else begin
                        zout_q  <= res_c;
                        cy_q    <= cy_c;
                        zf_q    <= res_c == '0;
                        vld_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_RUN: begin
                    sh_q  <= sh_n;
                    acc_q <= acc_n;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        zout_q  <= fin_z;
                        cy_q    <= fin_cy;
                        zf_q    <= fin_z == '0;
                        vld_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: if (bus.out_ready) begin
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.Zout      = zout_q;
    assign bus.CYout     = cy_q;
    assign bus.ZF        = zf_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random checks of alu_mc against an
// arithmetic reference model of each op, its flags and latency.
module tb_alu_mc;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    alu_mc_if #(.WIDTH(16)) bus ();

    alu_mc #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_op(
        input  logic [4:0]  op,
        input  logic [15:0] a,
        input  logic [15:0] b,
        input  logic        c,
        output logic [15:0] z,
        output logic        zc,
        output int          lat
    );
        logic [16:0]        s;
        logic [31:0]        t;
        logic signed [31:0] ts;
        int                 n;
        n   = int'(b[3:0]);
        lat = 1;
        zc  = c;
        z   = '0;
        case (op)
            5'd0:  z = a;
            5'd1:  z = b;
            5'd2:  z = ~a;
            5'd3:  z = ~b;
            5'd4:  begin s = 17'(a) + 17'(b); z = s[15:0]; zc = s[16]; end
            5'd5:  begin
                s = 17'(a) + 17'(b) + 17'(c);
                z = s[15:0]; zc = s[16];
            end
            5'd6:  z = a | b;
            5'd7:  z = a & b;
            5'd8:  z = 16'h0000;
            5'd9:  z = 16'h0001;
            5'd10: z = 16'hFFFF;
            5'd11: begin z = 16'h0000; zc = 1'b0; end
            5'd12: begin z = 16'h0001; zc = 1'b1; end
            5'd13: begin z = a + 16'd1; zc = (a == 16'hFFFF); end
            5'd14: begin z = a - 16'd1; zc = (a == 16'h0000); end
            5'd15: begin z = a - b; zc = (a < b); end
            5'd16: begin
                z = a;
                if (n != 0) begin
                    t = 32'(a) << n; z = t[15:0]; zc = t[16]; lat = n + 1;
                end
            end
            5'd17: begin
                z = a;
                if (n != 0) begin
                    t = {a, 16'h0} >> n; z = t[31:16]; zc = t[15]; lat = n + 1;
                end
            end
            5'd18: begin
                z = a;
                if (n != 0) begin
                    ts = {a, 16'h0}; ts = ts >>> n;
                    z = ts[31:16]; zc = ts[15]; lat = n + 1;
                end
            end
            5'd19: begin
                t = 32'(a) * 32'(b); z = t[15:0]; zc = |t[31:16]; lat = 17;
            end
            default: z = 16'h0000;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        int i;
        bus.ALU_op   = op;
        bus.busA     = a;
        bus.busB     = b;
        bus.CY       = c;
        bus.in_valid = 1'b1;
        i = 0;
        while (!bus.in_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("issue_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int exp_lat,
                           input logic [15:0] ez, input logic ecy);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_z"}, 32'(bus.Zout), 32'(ez));
        check({tag, "_cy"}, 32'(bus.CYout), 32'(ecy));
        check({tag, "_zf"}, 32'(bus.ZF), 32'(ez == 16'h0));
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("retire_vld", 32'(bus.out_valid), 32'd0);
        check("retire_rdy", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_ref(input string tag, input logic [4:0] op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic c);
        logic [15:0] ez;
        logic        ecy;
        int          el;
        ref_op(op, a, b, c, ez, ecy, el);
        issue(op, a, b, c);
        collect(tag, el, ez, ecy);
    endtask

    initial begin
        logic [4:0]  op;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [15:0] hz;
        int          hold;
        n_chk         = 0;
        n_fail        = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.busA      = '0;
        bus.busB      = '0;
        bus.CY        = 1'b0;
        bus.ALU_op    = '0;
        rst_n         = 1'b0;
        #12;
        check("rst_rdy", 32'(bus.in_ready), 32'd1);
        check("rst_vld", 32'(bus.out_valid), 32'd0);
        check("rst_z", 32'(bus.Zout), 32'd0);
        check("rst_cy", 32'(bus.CYout), 32'd0);
        check("rst_zf", 32'(bus.ZF), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(5'd4, 16'hFFFF, 16'h0001, 1'b0);
        collect("add", 1, 16'h0000, 1'b1);
        retire();
        issue(5'd15, 16'h0003, 16'h0005, 1'b0);
        collect("sub", 1, 16'hFFFE, 1'b1);
        retire();
        issue(5'd16, 16'h2001, 16'd3, 1'b0);
        collect("shl", 4, 16'h0008, 1'b1);
        retire();
        issue(5'd18, 16'h8000, 16'd15, 1'b1);
        collect("sar", 16, 16'hFFFF, 1'b0);
        retire();
        issue(5'd17, 16'hA5A5, 16'h0010, 1'b1);
        collect("shr0", 1, 16'hA5A5, 1'b1);
        retire();
        issue(5'd19, 16'h00FF, 16'h0003, 1'b0);
        collect("mul1", 17, 16'h02FD, 1'b0);
        retire();
        issue(5'd19, 16'h0100, 16'h0100, 1'b0);
        collect("mul2", 17, 16'h0000, 1'b1);
        retire();

        issue(5'd14, 16'h0000, 16'h0000, 1'b0);
        collect("dec", 1, 16'hFFFF, 1'b1);
        bus.ALU_op   = 5'd0;
        bus.busA     = 16'h1234;
        bus.busB     = 16'h0000;
        bus.CY       = 1'b0;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_z", 32'(bus.Zout), 32'hFFFF);
            check("bp_cy", 32'(bus.CYout), 32'd1);
            check("bp_rdy", 32'(bus.in_ready), 32'd0);
            check("bp_vld", 32'(bus.out_valid), 32'd1);
        end
        retire();
        issue(5'd0, 16'h1234, 16'h0000, 1'b0);
        collect("pend", 1, 16'h1234, 1'b0);
        retire();

        issue(5'd19, 16'hFFFF, 16'hFFFF, 1'b1);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_vld", 32'(bus.out_valid), 32'd0);
        check("mrst_rdy", 32'(bus.in_ready), 32'd1);
        check("mrst_z", 32'(bus.Zout), 32'd0);
        check("mrst_cy", 32'(bus.CYout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(5'd13, 16'hFFFF, 16'h0000, 1'b0);
        collect("inc", 1, 16'h0000, 1'b1);
        retire();

        issue(5'd25, 16'h1111, 16'h2222, 1'b1);
        collect("op25", 1, 16'h0000, 1'b1);
        retire();
        issue(5'd12, 16'h1111, 16'h2222, 1'b0);
        collect("op12", 1, 16'h0001, 1'b1);
        retire();
        issue(5'd11, 16'h1111, 16'h2222, 1'b1);
        collect("op11", 1, 16'h0000, 1'b0);
        retire();

        for (int k = 0; k < 120; k++) begin
            op = 5'($urandom_range(0, 31));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (k % 4 == 0) ra = (k % 8 == 0) ? 16'hFFFF : 16'h0000;
            run_ref("rnd", op, ra, rb, rc);
            hz   = bus.Zout;
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("rnd_hold", 32'(bus.Zout), 32'(hz));
            end
            retire();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
